// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, condition-code bit
// positions and controller states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LSL = 4'd2;
  localparam logic [3:0] OP_ASH = 4'd3;
  localparam logic [3:0] OP_LSH = 4'd4;
  localparam logic [3:0] OP_ROL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_XOR = 4'd11;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [3:0] pack_cc(input logic n, input logic z,
                                         input logic v, input logic c);
    logic [3:0] f;
    f       = '0;
    f[CC_N] = n;
    f[CC_Z] = z;
    f[CC_V] = v;
    f[CC_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative signed multiplier: unsigned shift-add on operand magnitudes,
// one multiplier bit per cycle, sign applied to the finished product.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             running;
  logic             neg;

  // Negating in double width keeps the most-negative operand exact.
  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    a_mag = a[WIDTH-1] ? (PW'(0) - a_ext) : a_ext;
    b_mag = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
  end

  // Bit 0 of the multiplier is folded in on the start cycle, so the
  // remaining WIDTH-1 bits finish as the counter runs down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      neg     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= b_mag[0] ? a_mag : '0;
        mcand   <= a_mag << 1;
        mplier  <= b_mag >> 1;
        cnt     <= CW'(WIDTH - 1);
        neg     <= a[WIDTH-1] ^ b[WIDTH-1];
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = neg ? (PW'(0) - acc) : acc;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes, registered result/flags and an
// iterative multiplier; single-cycle ops give one result per cycle.
//
//   state   | meaning
//   IDLE    | no result pending, ready for a request
//   BUSY    | multiply iterating, requests refused
//   HOLD    | result presented until the consumer takes it
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             op_dir,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic               accept;
  logic               start_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic               mul_v;

  logic [SHW-1:0]     sh;
  logic [SHW-1:0]     sh_neg;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     sub_x;
  logic [WIDTH:0]     lsh_x;
  logic [WIDTH:0]     rsh_x;
  logic [WIDTH:0]     ash_x;
  logic [WIDTH-1:0]   sgn_x;
  logic [WIDTH-1:0]   rol_r;
  logic [WIDTH-1:0]   ror_r;
  logic               shl_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [3:0]         alu_cc;

  assign in_ready  = rst_n && ((state == ST_IDLE) || (state == ST_HOLD && out_ready));
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (val_a),
    .b       (val_b),
    .done    (mul_done),
    .product (mul_p)
  );

  assign mul_v = (mul_p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_p[WIDTH-1]}});

  always_comb begin
    sh     = val_b[SHW-1:0];
    sh_neg = SHW'(0) - sh;
    add_x  = {1'b0, val_a} + {1'b0, val_b};
    sub_x  = {1'b0, val_a} - {1'b0, val_b};
    // Extra bit beyond the word catches the last bit shifted out.
    lsh_x  = {1'b0, val_a} << sh;
    rsh_x  = {val_a, 1'b0} >> sh;
    ash_x  = $signed({val_a, 1'b0}) >>> sh;
    // Top sh+1 bits of A must all match the sign for a clean left shift.
    sgn_x  = $signed(val_a) >>> (SHW'(WIDTH - 1) - sh);
    shl_v  = !((&sgn_x) || (~|sgn_x));
    rol_r  = (val_a << sh) | (val_a >> sh_neg);
    ror_r  = (val_a >> sh) | (val_a << sh_neg);

    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_x[WIDTH-1:0];
        alu_c   = add_x[WIDTH];
        alu_v   = (val_a[WIDTH-1] == val_b[WIDTH-1]) && (add_x[WIDTH-1] != val_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_x[WIDTH-1:0];
        alu_c   = sub_x[WIDTH];
        alu_v   = (val_a[WIDTH-1] != val_b[WIDTH-1]) && (sub_x[WIDTH-1] != val_a[WIDTH-1]);
      end
      OP_LSL: begin
        alu_res = lsh_x[WIDTH-1:0];
        alu_c   = lsh_x[WIDTH];
        alu_v   = shl_v;
      end
      OP_ASH: begin
        if (op_dir) begin
          alu_res = lsh_x[WIDTH-1:0];
          alu_c   = lsh_x[WIDTH];
          alu_v   = shl_v;
        end else begin
          alu_res = ash_x[WIDTH:1];
          alu_c   = ash_x[0];
        end
      end
      OP_LSH: begin
        if (op_dir) begin
          alu_res = lsh_x[WIDTH-1:0];
          alu_c   = lsh_x[WIDTH];
          alu_v   = shl_v;
        end else begin
          alu_res = rsh_x[WIDTH:1];
          alu_c   = rsh_x[0];
        end
      end
      OP_ROL: begin
        alu_res = rol_r;
        alu_c   = (sh != '0) && rol_r[0];
      end
      OP_ROR: begin
        alu_res = ror_r;
        alu_c   = (sh != '0) && ror_r[WIDTH-1];
      end
      OP_AND:  alu_res = val_a & val_b;
      OP_OR:   alu_res = val_a | val_b;
      OP_NOT:  alu_res = ~val_a;
      OP_XOR:  alu_res = val_a ^ val_b;
      default: alu_res = '0;
    endcase
    alu_cc = pack_cc(alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      cc     <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        state <= ST_BUSY;
      end else begin
        result <= alu_res;
        cc     <= alu_cc;
        state  <= ST_HOLD;
      end
    end else begin
      case (state)
        ST_BUSY: begin
          if (mul_done) begin
            result <= mul_p[WIDTH-1:0];
            cc     <= pack_cc(mul_p[WIDTH-1], mul_p[WIDTH-1:0] == '0, mul_v, mul_v);
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus random
// traffic checked every cycle against an arithmetic reference model.
module tb_alu_seq;

  localparam int     W    = 16;
  localparam longint MASK = (longint'(1) << W) - 1;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic         op_dir = 1'b0;
  logic [W-1:0] val_a = '0;
  logic [W-1:0] val_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   cc;

  int n_chk = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_dir    (op_dir),
    .val_a     (val_a),
    .val_b     (val_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cc        (cc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {result, N, Z, V, C} from plain integer arithmetic.
  function automatic logic [W+3:0] ref_op(input int o, input bit d, input longint a, input longint b);
    longint       r, sa, sb, p;
    bit           c, v, sgn, bt;
    int           n;
    logic [W-1:0] rr;
    sa = (a > MAXS) ? a - (MASK + 1) : a;
    sb = (b > MAXS) ? b - (MASK + 1) : b;
    n  = int'(b % W);
    r = 0; c = 0; v = 0;
    case (o)
      0: begin p = a + b; r = p & MASK; c = (p > MASK); v = (sa + sb > MAXS) || (sa + sb < MINS); end
      1: begin r = (a - b) & MASK; c = (a < b); v = (sa - sb > MAXS) || (sa - sb < MINS); end
      2, 3, 4: begin
        r = a;
        if (o == 2 || d) begin
          sgn = ((a >> (W - 1)) & 1) != 0;
          for (int i = 0; i < n; i++) begin
            bt = ((r >> (W - 1)) & 1) != 0;
            if (bt != sgn) v = 1;
            c = bt;
            r = (r << 1) & MASK;
          end
          if ((((r >> (W - 1)) & 1) != 0) != sgn) v = 1;
        end else begin
          for (int i = 0; i < n; i++) begin
            c = (r & 1) != 0;
            if (o == 3) r = (r >> 1) | (r & (longint'(1) << (W - 1)));
            else        r = r >> 1;
          end
        end
      end
      5: for (int i = 0; i < n; i++) begin
           bt = ((r >> (W - 1)) & 1) != 0;
           if (i == 0) r = a;
           bt = ((r >> (W - 1)) & 1) != 0;
           r = ((r << 1) & MASK) | longint'(bt);
           c = bt;
         end
      6: for (int i = 0; i < n; i++) begin
           if (i == 0) r = a;
           bt = (r & 1) != 0;
           r = (r >> 1) | (longint'(bt) << (W - 1));
           c = bt;
         end
      7: begin p = sa * sb; r = p & MASK; v = (p > MAXS) || (p < MINS); c = v; end
      8:  r = a & b;
      9:  r = a | b;
      10: r = (~a) & MASK;
      11: r = a ^ b;
      default: r = 0;
    endcase
    if ((o == 5 || o == 6) && n == 0) r = a;
    rr = r[W-1:0];
    return {rr, rr[W-1], (rr == '0), v, c};
  endfunction

  // Behavioural model of the handshake: cycles left on a multiply, and
  // whether a result is currently on offer.
  int           m_busy = 0;
  bit           m_hold = 0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_cc = '0;
  logic [W+3:0] m_pend = '0;
  bit           m_rdy, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_hold = 0;
    end else begin
      m_rdy = (m_busy == 0 && !m_hold) || (m_hold && out_ready);
      m_acc = in_valid && m_rdy;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hold = 1;
          {m_res, m_cc} = m_pend;
        end
      end else begin
        if (m_hold && out_ready) m_hold = 0;
        if (m_acc) begin
          if (op == 4'd7) begin
            m_busy = W;
            m_pend = ref_op(op, op_dir, val_a, val_b);
          end else begin
            m_hold = 1;
            {m_res, m_cc} = ref_op(op, op_dir, val_a, val_b);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_cc", cc, 0);
    end else begin
      check("in_ready", in_ready, (m_busy == 0 && !m_hold) || (m_hold && out_ready));
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
        check("model_result", result, m_res);
        check("model_cc", cc, m_cc);
      end
    end
  end

  // Issue one op from IDLE, wait (bounded) for the result and check it.
  task automatic run_op(input string name, input logic [3:0] o, input logic d,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [3:0] ec,
                        input int elat, input bit release_it);
    int lat;
    in_valid = 1; op = o; op_dir = d; val_a = a; val_b = b; out_ready = 0;
    @(posedge clk); #2;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_result"}, result, er);
    check({name, "_cc"}, cc, ec);
    if (release_it) begin
      out_ready = 1;
      @(posedge clk); #2;
      out_ready = 0;
    end
  endtask

  logic [W-1:0] xa [3];
  logic [W-1:0] xb [3];
  logic [W-1:0] xr [3];
  logic [W-1:0] specials [5];

  initial begin
    xa = '{16'h1234, 16'hFFFF, 16'hA5A5};
    xb = '{16'h00FF, 16'hFFFF, 16'h5A5A};
    xr = '{16'h12CB, 16'h0000, 16'hFFFF};
    specials = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    check("pin_add", ref_op(0, 0, 'h7FFF, 1), {16'h8000, 4'b1010});
    check("pin_sub", ref_op(1, 0, 0, 1), {16'hFFFF, 4'b1001});
    check("pin_ash", ref_op(3, 0, 'hC000, 4), {16'hFC00, 4'b1000});
    check("pin_lsl", ref_op(2, 0, 'h4000, 1), {16'h8000, 4'b1010});
    check("pin_ror", ref_op(6, 0, 'h0001, 1), {16'h8000, 4'b1001});
    check("pin_mul", ref_op(7, 0, 'h8000, 'h8000), {16'h0000, 4'b0111});

    @(posedge clk); #2;
    run_op("add_ovf", 4'd0, 0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1, 1);
    run_op("sub_neg", 4'd1, 0, 16'd10, 16'd20, 16'hFFF6, 4'b1001, 1, 1);
    run_op("sub_zero", 4'd1, 0, 16'd10, 16'd10, 16'h0000, 4'b0100, 1, 1);
    run_op("mul_small", 4'd7, 0, 16'd10, 16'd202, 16'h07E4, 4'b0000, 17, 1);
    run_op("mul_ovf", 4'd7, 0, 16'd10000, 16'd10000, 16'hE100, 4'b1011, 17, 1);
    run_op("mul_minneg", 4'd7, 0, 16'h8000, 16'd2, 16'h0000, 4'b0111, 17, 1);
    run_op("lsl_c000", 4'd2, 0, 16'hC000, 16'd4, 16'h0000, 4'b0110, 1, 1);
    run_op("ash_right", 4'd3, 0, 16'hC000, 16'd4, 16'hFC00, 4'b1000, 1, 1);
    run_op("rol_c000", 4'd5, 0, 16'hC000, 16'd4, 16'h000C, 4'b0000, 1, 1);
    run_op("ror_0003", 4'd6, 0, 16'h0003, 16'd4, 16'h3000, 4'b0000, 1, 1);
    run_op("reserved", 4'd13, 1, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1, 1);

    // Backpressure: result must sit still while a new request is offered.
    run_op("and_bp", 4'd8, 0, 16'h000A, 16'h000C, 16'h0008, 4'b0000, 1, 0);
    in_valid = 1; op = 4'd9; val_a = 16'hFFFF; val_b = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      check("bp_result", result, 16'h0008);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end

    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; op = 4'd11; val_a = xa[k]; val_b = xb[k];
      @(posedge clk); #2;
      check("stream_valid", out_valid, 1);
      check("stream_result", result, xr[k]);
    end
    in_valid = 0;
    @(posedge clk); #2;
    out_ready = 0;

    // Reset in the middle of a multiply.
    in_valid = 1; op = 4'd7; val_a = 16'd10; val_b = 16'd202;
    @(posedge clk); #2;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_cc", cc, 0);
    check("rst_mid_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (20) @(posedge clk);
    #2;
    check("rst_no_emit", out_valid, 0);
    run_op("add_after_rst", 4'd0, 0, 16'd3, 16'd4, 16'd7, 4'b0000, 1, 1);

    // Random traffic, checked cycle by cycle against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      op_dir    = 1'($urandom_range(0, 1));
      val_a     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      val_b     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      @(posedge clk); #2;
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (40) @(posedge clk);
    #2;
    check("final_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the 16-bit combinational ALU.
- Adds a valid/ready handshake on input and output, registered result and condition codes, and an iterative multi-cycle signed multiplier.
- Non-multiply ops complete in one cycle.
- Sits between the register-file read stage and writeback; result is held until the consumer accepts it.

Parameters:
- WIDTH, 16, datapath width; power of two, 4..64.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode (see Behaviour).
- op_dir  in  1  shift direction for ASH/LSH: 1 = left, 0 = right.
- val_a  in  WIDTH  operand A.
- val_b  in  WIDTH  operand B; shift/rotate amount = val_b[SHW-1:0].
- out_valid  out  1  result and cc are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- cc  out  4  registered condition codes {N,Z,V,C} = cc[3:0].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0, cc=0, out_valid=0, in_ready=0 while in reset.
  - Any in-flight multiply is discarded.
- States: IDLE, BUSY (multiply iterating), HOLD (result presented).
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - out_valid = (state==HOLD).
  - Accept = in_valid && in_ready; operands and op are captured on accept.
- Transitions:
  - Accept of non-MUL op: result and cc are computed and registered; next state HOLD. out_valid rises the cycle after accept (latency 1).
  - Accept of MUL: next state BUSY; iteration counter loads WIDTH-1. BUSY runs WIDTH cycles, then goes to HOLD. out_valid rises WIDTH+1 cycles after accept.
  - HOLD with out_ready=0: result and cc are held stable; in_ready=0.
  - HOLD with out_ready=1 and no accept: next state IDLE.
  - HOLD with out_ready=1 and accept (back-to-back): the new op is processed as if from IDLE, giving one result per cycle for non-MUL streams.
  - In BUSY, in_valid is ignored; in_ready=0.
- Opcodes:
  - 0 ADD.
  - 1 SUB (A-B).
  - 2 LSL (left logical).
  - 3 ASH (arithmetic shift, op_dir selects direction).
  - 4 LSH (logical shift, op_dir selects direction).
  - 5 ROL.
  - 6 ROR.
  - 7 MUL (signed).
  - 8 AND.
  - 9 OR.
  - 10 NOT A.
  - 11 XOR.
  - 12-15 reserved: result=0, cc={0,1,0,0}.
- Flags for all ops: N = result[WIDTH-1]; Z = (result==0).
- ADD: C = carry out; V = signed overflow.
- SUB: C = borrow (A<B unsigned); V = signed overflow.
- Shifts:
  - C = last bit shifted out; C=0 when amount=0.
  - V (left shifts only) = 1 if any bit shifted out differs from the original sign bit, or the result sign differs from the original sign.
  - V=0 for right shifts and rotates.
- Rotates: C = last bit rotated across the boundary (0 if amount 0).
- MUL:
  - Signed WIDTH x WIDTH product; result = low WIDTH bits.
  - V=1 if the 2*WIDTH product is not representable as a signed WIDTH value; C=V.
  - Algorithm: magnitudes of A and B, unsigned shift-add one bit per cycle over WIDTH cycles, then 2's-complement negate if the operand signs differ.
  - Most-negative operands are handled via 2*WIDTH intermediate width.
- Logic ops: V=C=0.
- Reset asserted mid-BUSY or mid-HOLD: immediately IDLE, outputs cleared, no result emitted.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_XOR);
  - cc bit indices (CC_N=3, CC_Z=2, CC_V=1, CC_C=0);
  - state encoding.
- Sub-module alu_seq_mul: iterative signed multiplier.
  - Inputs: start, a, b. Outputs: done pulse, 2*WIDTH product.
  - Same clk/rst_n.
- Top block holds the FSM, the combinational single-cycle ops, and the output registers.

Test Plan:
- ADD 32767+1 (WIDTH=16) -> result 0x8000, cc N=1,Z=0,V=1,C=0, out_valid one cycle after accept.
- SUB 10-20 -> 0xFFF6, N=1,V=0,C=1. SUB 10-10 -> 0x0000, Z=1.
- MUL 10*202 -> 0x07E4, V=0, out_valid exactly 17 cycles after accept. MUL 10000*10000 -> 0xE100, N=1,V=1. MUL 0x8000*2 -> 0x0000, Z=1,V=1.
- Shifts:
  - LSL 0xC000 by 4 -> 0x0000, Z=1,V=1,C=0.
  - ASH right 0xC000 by 4 -> 0xFC00, N=1.
  - ROL 0xC000 by 4 -> 0x000C, C=0.
  - ROR 0x0003 by 4 -> 0x3000.
- Backpressure: hold out_ready=0 for 5 cycles after an AND 0xA&0xC -> result 0x0008 stays stable, in_ready=0. Then stream 3 back-to-back XOR ops with out_ready=1 -> one result per cycle.
- Reset: assert rst_n=0 at cycle 5 of a MUL -> out_valid=0, result=0, cc=0 immediately. After release, a new ADD completes normally.
